// File: rtl/bus_seq_pkg.sv
// Shared definitions for the bus transfer sequencer: op codes, FSM states,
// per-op routing flags and the command-rejection rule.
package bus_seq_pkg;

    localparam int unsigned OP_W = 2;

    typedef enum logic [OP_W-1:0] {
        OP_LOAD_IMM   = 2'b00,
        OP_MOVE       = 2'b01,
        OP_ZERO       = 2'b10,
        OP_DRIVE_ONLY = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        StIdle,
        StDrive,
        StWrite,
        StDone,
        StErr
    } state_e;

    // Which datapath resources an op touches.
    typedef struct packed {
        logic uses_temp;
        logic uses_src;
        logic uses_dst;
    } op_route_t;

    function automatic int unsigned cmd_width(input int unsigned data_w, input int unsigned sel_w);
        return OP_W + 2 * sel_w + data_w;
    endfunction

    function automatic op_route_t op_route(input op_e op);
        op_route_t r;
        r.uses_temp = (op == OP_LOAD_IMM) || (op == OP_ZERO);
        r.uses_src  = (op == OP_MOVE) || (op == OP_DRIVE_ONLY);
        r.uses_dst  = (op != OP_DRIVE_ONLY);
        return r;
    endfunction

    // Full-width index compare so an out-of-range index is rejected, never wrapped.
    function automatic logic cmd_reject(input op_e op, input int unsigned src,
                                        input int unsigned dst, input int unsigned num_regs);
        op_route_t r;
        logic      bad;
        r   = op_route(op);
        bad = 1'b0;
        if (r.uses_src && (src >= num_regs)) bad = 1'b1;
        if (r.uses_dst && (dst >= num_regs)) bad = 1'b1;
        if ((op == OP_MOVE) && (src == dst)) bad = 1'b1;
        return bad;
    endfunction

endpackage

// File: rtl/bus_seq_cmd_buf.sv
// One-entry valid/ready command buffer with fall-through when empty, so an
// idle consumer sees a command in the same cycle it is offered.
module bus_seq_cmd_buf #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic [WIDTH-1:0] up_data,
    output logic             dn_valid,
    input  logic             dn_ready,
    output logic [WIDTH-1:0] dn_data
);

    logic             full_q;
    logic [WIDTH-1:0] data_q;

    assign up_ready = !full_q;
    assign dn_valid = full_q || up_valid;
    assign dn_data  = full_q ? data_q : up_data;

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else if (full_q) begin
            if (dn_ready) full_q <= 1'b0;
        end else if (up_valid && !dn_ready) begin
            full_q <= 1'b1;
            data_q <= up_data;
        end
    end

endmodule

// File: rtl/bus_transfer_sequencer.sv
// Sequences register-out / temp / register-in strobes for one bus transfer per command.
// Define SEQ_CMD_BUF_EN to add a 1-entry command buffer (back-to-back DONE -> DRIVE).
module bus_transfer_sequencer
    import bus_seq_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned SEL_W    = 5
) (
    input  logic                clock,
    input  logic                clear,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_op,
    input  logic [SEL_W-1:0]    cmd_src,
    input  logic [SEL_W-1:0]    cmd_dst,
    input  logic [DATA_W-1:0]   cmd_imm,
    output logic [NUM_REGS-1:0] reg_out,
    output logic [NUM_REGS-1:0] reg_in,
    output logic [DATA_W-1:0]   temp_data,
    output logic                temp_enable,
    output logic                busy,
    output logic                done,
    output logic                err
);

    state_e                state;
    logic                  in_valid;
    logic                  in_ready;
    logic [1:0]            in_op_raw;
    op_e                   in_op;
    logic [SEL_W-1:0]      in_src;
    logic [SEL_W-1:0]      in_dst;
    logic [DATA_W-1:0]     in_imm;
    op_route_t             route;
    logic                  reject;
    logic [NUM_REGS-1:0]   src_hot;
    logic [NUM_REGS-1:0]   dst_hot;
    logic [NUM_REGS-1:0]   dst_hot_q;

`ifdef SEQ_CMD_BUF_EN
    localparam int unsigned CMD_W = cmd_width(DATA_W, SEL_W);
    logic [CMD_W-1:0] in_cmd;

    bus_seq_cmd_buf #(
        .WIDTH (CMD_W)
    ) u_cmd_buf (
        .clock    (clock),
        .clear    (clear),
        .up_valid (cmd_valid),
        .up_ready (cmd_ready),
        .up_data  ({cmd_op, cmd_src, cmd_dst, cmd_imm}),
        .dn_valid (in_valid),
        .dn_ready (in_ready),
        .dn_data  (in_cmd)
    );

    assign {in_op_raw, in_src, in_dst, in_imm} = in_cmd;
    // DONE may hand straight over to the next buffered command.
    assign in_ready = (state == StIdle) || (state == StDone);
`else
    assign in_valid  = cmd_valid;
    assign in_op_raw = cmd_op;
    assign in_src    = cmd_src;
    assign in_dst    = cmd_dst;
    assign in_imm    = cmd_imm;
    assign in_ready  = (state == StIdle);
    assign cmd_ready = in_ready;
`endif

    assign in_op  = op_e'(in_op_raw);
    assign route  = op_route(in_op);
    assign reject = cmd_reject(in_op, 32'(in_src), 32'(in_dst), NUM_REGS);
    assign busy   = (state != StIdle);

    always_comb begin
        src_hot = '0;
        dst_hot = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            src_hot[i] = (in_src == SEL_W'(i));
            dst_hot[i] = (in_dst == SEL_W'(i));
        end
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state       <= StIdle;
            reg_out     <= '0;
            reg_in      <= '0;
            temp_enable <= 1'b0;
            temp_data   <= '0;
            done        <= 1'b0;
            err         <= 1'b0;
            dst_hot_q   <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                StIdle, StDone: begin
                    if (in_valid && in_ready) begin
                        if (reject) begin
                            state <= StErr;
                            err   <= 1'b1;
                        end else begin
                            state       <= StDrive;
                            temp_enable <= route.uses_temp;
                            reg_out     <= route.uses_src ? src_hot : '0;
                            dst_hot_q   <= route.uses_dst ? dst_hot : '0;
                            if (route.uses_temp) begin
                                temp_data <= (in_op == OP_LOAD_IMM) ? in_imm : '0;
                            end
                        end
                    end else begin
                        state <= StIdle;
                    end
                end
                StDrive: begin
                    state  <= StWrite;
                    reg_in <= dst_hot_q;
                end
                StWrite: begin
                    state       <= StDone;
                    reg_out     <= '0;
                    reg_in      <= '0;
                    temp_enable <= 1'b0;
                    done        <= 1'b1;
                end
                StErr:   state <= StIdle;
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_transfer_sequencer.sv
// Bench for bus_transfer_sequencer: schedule-based reference model checked every cycle,
// a behavioural register file driven by the strobes, and directed literal checks.
module tb_bus_transfer_sequencer;

    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 16;
    localparam int SEL_W    = 5;
    localparam int MAXC     = 512;
    localparam logic [1:0] LD = 2'b00, MV = 2'b01, ZR = 2'b10, DR = 2'b11;
`ifdef SEQ_CMD_BUF_EN
    localparam bit BUF = 1'b1;
`else
    localparam bit BUF = 1'b0;
`endif

    logic                clock = 1'b0;
    logic                clear = 1'b0;
    logic                cmd_valid = 1'b0;
    logic                cmd_ready;
    logic [1:0]          cmd_op = '0;
    logic [SEL_W-1:0]    cmd_src = '0;
    logic [SEL_W-1:0]    cmd_dst = '0;
    logic [DATA_W-1:0]   cmd_imm = '0;
    logic [NUM_REGS-1:0] reg_out, reg_in;
    logic [DATA_W-1:0]   temp_data;
    logic                temp_enable, busy, done, err;

    bus_transfer_sequencer #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .SEL_W    (SEL_W)
    ) dut (
        .clock       (clock),
        .clear       (clear),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_src     (cmd_src),
        .cmd_dst     (cmd_dst),
        .cmd_imm     (cmd_imm),
        .reg_out     (reg_out),
        .reg_in      (reg_in),
        .temp_data   (temp_data),
        .temp_enable (temp_enable),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @t=%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Datapath register file fed by the strobes.
    logic [DATA_W-1:0] regs [NUM_REGS] = '{default: '0};
    always @(posedge clock) begin
        logic [DATA_W-1:0] bus;
        bus = temp_enable ? temp_data : '0;
        for (int i = 0; i < NUM_REGS; i++) if (reg_out[i]) bus = regs[i];
        for (int i = 0; i < NUM_REGS; i++) if (reg_in[i]) regs[i] <= bus;
    end

    // Reference model: each accepted command writes its outputs into a per-cycle timeline.
    typedef struct {
        logic [1:0]        op;
        logic [SEL_W-1:0]  src;
        logic [SEL_W-1:0]  dst;
        logic [DATA_W-1:0] imm;
    } cmd_t;

    cmd_t                pend[$];
    int                  cyc;
    int                  take_from;
    bit                  m_ready;
    logic [DATA_W-1:0]   m_td;
    logic [NUM_REGS-1:0] e_out [MAXC];
    logic [NUM_REGS-1:0] e_in  [MAXC];
    bit                  e_te  [MAXC];
    bit                  e_done[MAXC];
    bit                  e_err [MAXC];
    bit                  e_busy[MAXC];

    always @(posedge clock or negedge clear) begin
        if (!clear) begin
            cyc = 0;
            take_from = 0;
            m_ready = 1'b1;
            m_td = '0;
            pend.delete();
            for (int i = 0; i < MAXC; i++) begin
                e_out[i] = '0; e_in[i] = '0; e_te[i] = 0;
                e_done[i] = 0; e_err[i] = 0; e_busy[i] = 0;
            end
        end else begin
            cyc++;
            if (cmd_valid && m_ready) pend.push_back('{cmd_op, cmd_src, cmd_dst, cmd_imm});
            if (pend.size() > 0 && cyc >= take_from && cyc + 3 < MAXC) begin
                cmd_t                c;
                bit                  bad;
                logic [NUM_REGS-1:0] one;
                c   = pend.pop_front();
                one = 1;
                bad = 0;
                if ((c.op == MV || c.op == DR) && int'(c.src) >= NUM_REGS) bad = 1;
                if (c.op != DR && int'(c.dst) >= NUM_REGS) bad = 1;
                if (c.op == MV && c.src == c.dst) bad = 1;
                if (bad) begin
                    e_err[cyc]  = 1;
                    e_busy[cyc] = 1;
                    take_from   = cyc + 2;
                end else begin
                    for (int t = cyc; t < cyc + 3; t++) e_busy[t] = 1;
                    if (c.op == LD || c.op == ZR) begin
                        e_te[cyc] = 1; e_te[cyc+1] = 1;
                        m_td = (c.op == LD) ? c.imm : '0;
                    end else begin
                        e_out[cyc] = one << c.src; e_out[cyc+1] = one << c.src;
                    end
                    if (c.op != DR) e_in[cyc+1] = one << c.dst;
                    e_done[cyc+2] = 1;
                    take_from = cyc + (BUF ? 3 : 4);
                end
            end
            m_ready = BUF ? (pend.size() == 0) : (cyc + 1 >= take_from);
        end
    end

    always @(negedge clock) begin
        if (clear && cyc < MAXC) begin
            check("cmd_ready", 64'(cmd_ready), 64'(m_ready));
            check("busy", 64'(busy), 64'(e_busy[cyc]));
            check("done", 64'(done), 64'(e_done[cyc]));
            check("err", 64'(err), 64'(e_err[cyc]));
            check("temp_enable", 64'(temp_enable), 64'(e_te[cyc]));
            check("temp_data", 64'(temp_data), 64'(m_td));
            check("reg_out", 64'(reg_out), 64'(e_out[cyc]));
            check("reg_in", 64'(reg_in), 64'(e_in[cyc]));
            check("one_source", 64'(($countones(reg_out) + 32'(temp_enable)) <= 1), 64'(1));
            check("reg_in_onehot0", 64'($onehot0(reg_in)), 64'(1));
        end
    end

    int done_q[$];
    always @(negedge clock) if (clear && done) done_q.push_back(cyc);

    task automatic send(input logic [1:0] op, input int src, input int dst,
                        input logic [DATA_W-1:0] imm);
        int n;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_src   = SEL_W'(src);
        cmd_dst   = SEL_W'(dst);
        cmd_imm   = imm;
        n = 0;
        while (!cmd_ready && n < 30) begin
            @(negedge clock);
            n++;
        end
        if (n >= 30) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: cmd_ready stayed 0, expected 1 within 30 cycles");
        end
        @(posedge clock);
        @(negedge clock);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || !cmd_ready) && n < 40) begin
            @(negedge clock);
            n++;
        end
        if (n >= 40) begin
            n_tests++;
            n_fail++;
            $display("FAIL idle_timeout: busy=%0b cmd_ready=%0b, expected idle", busy, cmd_ready);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clock);
        check("rst_reg_out", 64'(reg_out), 64'(0));
        check("rst_reg_in", 64'(reg_in), 64'(0));
        check("rst_temp", 64'({temp_enable, temp_data}), 64'(0));
        check("rst_flags", 64'({busy, done, err}), 64'(0));
        clear = 1'b1;
        @(negedge clock);

        // LOAD_IMM dst=1 imm=186
        send(LD, 0, 1, 186);
        check("t1_c0_te", 64'({temp_enable, temp_data}), 64'({1'b1, 32'd186}));
        check("t1_c0_in", 64'(reg_in), 64'(0));
        @(negedge clock);
        check("t1_c1_te", 64'(temp_enable), 64'(1));
        check("t1_c1_in", 64'(reg_in), 64'(16'h0002));
        @(negedge clock);
        check("t1_c2_done", 64'({done, temp_enable, reg_in}), 64'({1'b1, 1'b0, 16'h0}));
        @(negedge clock);
        check("t1_c3_ready", 64'({done, cmd_ready}), 64'({1'b0, 1'b1}));
        check("t1_r1", 64'(regs[1]), 64'(186));

        // ZERO dst=2, then MOVE 1->2
        send(ZR, 0, 2, 32'hdead);
        wait_idle();
        check("t2_r2_zero", 64'(regs[2]), 64'(0));
        send(MV, 1, 2, 0);
        check("t2_c0_out", 64'({reg_out, reg_in}), 64'({16'h0002, 16'h0}));
        @(negedge clock);
        check("t2_c1_out", 64'({reg_out, reg_in}), 64'({16'h0002, 16'h0004}));
        @(negedge clock);
        check("t2_c2_done", 64'(done), 64'(1));
        wait_idle();
        check("t2_r2", 64'(regs[2]), 64'(186));

        // DRIVE_ONLY src=1
        send(DR, 1, 0, 0);
        check("t3_c0", 64'({reg_out, reg_in}), 64'({16'h0002, 16'h0}));
        @(negedge clock);
        check("t3_c1", 64'({reg_out, reg_in}), 64'({16'h0002, 16'h0}));
        @(negedge clock);
        check("t3_c2_done", 64'(done), 64'(1));
        wait_idle();
        check("t3_r0", 64'(regs[0]), 64'(0));

        // Rejected commands and the index boundary
        send(MV, 3, 3, 0);
        check("t4_same_err", 64'({err, done, temp_enable, reg_out, reg_in}), 64'({3'b100, 32'h0}));
        @(negedge clock);
        check("t4_same_idle", 64'({err, busy, cmd_ready}), 64'({3'b001}));
        send(MV, 1, 20, 0);
        check("t4_dst20_err", 64'({err, reg_out}), 64'({1'b1, 16'h0}));
        wait_idle();
        send(LD, 0, 16, 5);
        check("t4_dst16_err", 64'({err, temp_enable}), 64'({1'b1, 1'b0}));
        wait_idle();
        send(LD, 0, 15, 99);
        check("t4_dst15_ok", 64'({err, temp_enable}), 64'({1'b0, 1'b1}));
        wait_idle();
        check("t4_r15", 64'(regs[15]), 64'(99));

        // Three back-to-back LOAD_IMM
        done_q.delete();
        send(LD, 0, 4, 1);
        send(LD, 0, 5, 2);
        send(LD, 0, 6, 3);
        repeat (15) @(negedge clock);
        check("t6_done_count", 64'(done_q.size()), 64'(3));
        if (done_q.size() == 3) begin
            check("t6_gap1", 64'(done_q[1] - done_q[0]), 64'(BUF ? 3 : 4));
            check("t6_gap2", 64'(done_q[2] - done_q[1]), 64'(BUF ? 3 : 4));
        end
        check("t6_regs", 64'({regs[4][7:0], regs[5][7:0], regs[6][7:0]}), 64'(24'h010203));

        // Reset during WRITE
        send(LD, 0, 7, 77);
        @(posedge clock);
        #2 clear = 1'b0;
        #1;
        check("t5_strobes", 64'({temp_enable, reg_out, reg_in}), 64'(0));
        check("t5_flags", 64'({busy, done, err}), 64'(0));
        check("t5_temp_data", 64'(temp_data), 64'(0));
        @(negedge clock);
        clear = 1'b1;
        done_q.delete();
        repeat (5) @(negedge clock);
        check("t5_no_done", 64'(done_q.size()), 64'(0));
        check("t5_r7", 64'(regs[7]), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
